// File: rtl/rtc_pkg.sv
// rtc_pkg: encodings shared by the RTC main mode FSM and the bus sequencer.
// Build option: RTC_BUS_TIMER_EN extends the poll list with the timer registers.
package rtc_pkg;

    typedef enum logic [1:0] {
        MODE_RST  = 2'b00,
        MODE_INIT = 2'b01,
        MODE_READ = 2'b10,
        MODE_EDIT = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_GAP1,
        ST_DATA,
        ST_GAP2
    } bus_state_t;

    localparam logic [7:0] REG_CTRL_A = 8'h02;
    localparam logic [7:0] REG_CTRL_B = 8'h10;
    localparam logic [7:0] REG_SEC    = 8'h21;
    localparam logic [7:0] REG_MIN    = 8'h22;
    localparam logic [7:0] REG_HOUR   = 8'h23;
    localparam logic [7:0] REG_DAY    = 8'h24;
    localparam logic [7:0] REG_MONTH  = 8'h25;
    localparam logic [7:0] REG_YEAR   = 8'h26;
    localparam logic [7:0] REG_TMR0   = 8'h41;
    localparam logic [7:0] REG_TMR1   = 8'h42;
    localparam logic [7:0] REG_TMR2   = 8'h43;

    localparam int unsigned INIT_LEN = 3;
`ifdef RTC_BUS_TIMER_EN
    localparam int unsigned POLL_LEN = 9;
`else
    localparam int unsigned POLL_LEN = 6;
`endif

    // Init sequence: address/data pairs written in step order
    function automatic logic [7:0] init_addr(input logic [1:0] step);
        case (step)
            2'd0:    return REG_CTRL_A;
            2'd1:    return REG_CTRL_A;
            default: return REG_CTRL_B;
        endcase
    endfunction

    function automatic logic [7:0] init_data(input logic [1:0] step);
        case (step)
            2'd0:    return 8'h10;
            2'd1:    return 8'h00;
            default: return 8'hD2;
        endcase
    endfunction

    // Poll list: time registers, optionally followed by the timer registers
    function automatic logic [7:0] poll_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    return REG_SEC;
            4'd1:    return REG_MIN;
            4'd2:    return REG_HOUR;
            4'd3:    return REG_DAY;
            4'd4:    return REG_MONTH;
            4'd5:    return REG_YEAR;
`ifdef RTC_BUS_TIMER_EN
            4'd6:    return REG_TMR0;
            4'd7:    return REG_TMR1;
            4'd8:    return REG_TMR2;
`endif
            default: return REG_SEC;
        endcase
    endfunction

endpackage

// File: rtl/rtc_bus_phy.sv
// rtc_bus_phy: bus phase FSM, phase counter and registered strobe/drive encoding
// for one multiplexed address/data transaction.
module rtc_bus_phy
    import rtc_pkg::*;
#(
    parameter int PHASE_CYC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       start_read,
    input  logic [7:0] start_addr,
    input  logic [7:0] start_data,
    input  logic [7:0] ad_in,
    output logic       busy,
    output logic       capture,
    output logic       done,
    output logic [7:0] txn_addr,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad,
    output logic [7:0] ad_out,
    output logic       ad_oe
);

    localparam int CW = $clog2(PHASE_CYC);
    localparam logic [CW-1:0] LOAD = CW'(PHASE_CYC - 1);

    bus_state_t    state;
    logic [CW-1:0] cnt;
    logic          is_read;
    logic [7:0]    data_q;

    // Read data is sampled by the top on the last DATA cycle of a read
    assign capture = (state == ST_DATA) && (cnt == '0) && is_read;
    assign done    = (state == ST_GAP2);

    // Bus FSM; every output is set on the transition into the state it belongs to
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            is_read  <= 1'b0;
            txn_addr <= '0;
            data_q   <= '0;
            busy     <= 1'b0;
            cs_n     <= 1'b1;
            rd_n     <= 1'b1;
            wr_n     <= 1'b1;
            ad       <= 1'b0;
            ad_out   <= '0;
            ad_oe    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_ADDR;
                        cnt      <= LOAD;
                        is_read  <= start_read;
                        txn_addr <= start_addr;
                        data_q   <= start_data;
                        busy     <= 1'b1;
                        cs_n     <= 1'b0;
                        wr_n     <= 1'b0;
                        rd_n     <= 1'b1;
                        ad       <= 1'b0;
                        ad_oe    <= 1'b1;
                        ad_out   <= start_addr;
                    end
                end
                ST_ADDR: begin
                    if (cnt == '0) begin
                        state <= ST_GAP1;
                        cs_n  <= 1'b1;
                        wr_n  <= 1'b1;
                        rd_n  <= 1'b1;
                        ad_oe <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_GAP1: begin
                    state  <= ST_DATA;
                    cnt    <= LOAD;
                    cs_n   <= 1'b0;
                    ad     <= 1'b1;
                    wr_n   <= is_read;
                    rd_n   <= !is_read;
                    ad_oe  <= !is_read;
                    ad_out <= is_read ? '0 : data_q;
                end
                ST_DATA: begin
                    if (cnt == '0) begin
                        state <= ST_GAP2;
                        cs_n  <= 1'b1;
                        wr_n  <= 1'b1;
                        rd_n  <= 1'b1;
                        ad_oe <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_GAP2: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    ad     <= 1'b0;
                    ad_out <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/rtc_bus_seq.sv
// rtc_bus_seq: turns the main FSM mode into RTC bus transactions (init writes,
// round-robin time polling, user edits) and returns read data.
// Build option: RTC_BUS_TIMER_EN adds timer registers 0x41..0x43 to polling.
module rtc_bus_seq
    import rtc_pkg::*;
#(
    parameter int PHASE_CYC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       edit_valid,
    input  logic [7:0] edit_addr,
    input  logic [7:0] edit_data,
    output logic       edit_ready,
    output logic       rd_valid,
    output logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       init_done,
    output logic       busy,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    mode_t      mode_e;
    logic       start;
    logic       start_read;
    logic [7:0] start_addr;
    logic [7:0] start_data;
    logic       capture;
    logic       done;
    logic [7:0] txn_addr;
    logic [3:0] poll_idx;
    logic [3:0] use_idx;
    logic [3:0] next_idx;
    logic       in_poll;
    logic [1:0] init_step;
    logic       init_last;

    assign mode_e     = mode_t'(mode);
    assign edit_ready = !busy && (mode_e == MODE_EDIT);

    // A fresh entry into read mode restarts the poll list at its first entry
    assign use_idx  = in_poll ? poll_idx : '0;
    assign next_idx = (use_idx == 4'(POLL_LEN - 1)) ? '0 : use_idx + 4'd1;

    // Transaction selection, evaluated in each IDLE cycle
    always_comb begin
        start      = 1'b0;
        start_read = 1'b0;
        start_addr = '0;
        start_data = '0;
        if (!busy) begin
            case (mode_e)
                MODE_EDIT: begin
                    start      = edit_valid;
                    start_addr = edit_addr;
                    start_data = edit_data;
                end
                MODE_READ: begin
                    start      = 1'b1;
                    start_read = 1'b1;
                    start_addr = poll_addr(use_idx);
                end
                MODE_INIT: begin
                    start      = !init_done;
                    start_addr = init_addr(init_step);
                    start_data = init_data(init_step);
                end
                MODE_RST: begin
                    start = 1'b0;
                end
            endcase
        end
    end

    // Read return, poll index, init progress and init_done tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid  <= 1'b0;
            rd_addr   <= '0;
            rd_data   <= '0;
            init_done <= 1'b0;
            init_step <= '0;
            init_last <= 1'b0;
            poll_idx  <= '0;
            in_poll   <= 1'b0;
        end else begin
            rd_valid <= capture;
            if (capture) begin
                rd_addr <= txn_addr;
                rd_data <= ad_in;
            end
            if (done && init_last) begin
                init_done <= 1'b1;
                init_step <= '0;
                init_last <= 1'b0;
            end
            if (!busy) begin
                case (mode_e)
                    MODE_RST: begin
                        init_done <= 1'b0;
                        init_step <= '0;
                        in_poll   <= 1'b0;
                    end
                    MODE_INIT: begin
                        in_poll <= 1'b0;
                        if (!init_done) begin
                            init_step <= init_step + 2'd1;
                            init_last <= (init_step == 2'(INIT_LEN - 1));
                        end
                    end
                    MODE_READ: begin
                        init_step <= '0;
                        in_poll   <= 1'b1;
                        poll_idx  <= next_idx;
                    end
                    MODE_EDIT: begin
                        init_step <= '0;
                        in_poll   <= 1'b0;
                    end
                endcase
            end
        end
    end

    rtc_bus_phy #(
        .PHASE_CYC(PHASE_CYC)
    ) u_phy (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .start_read(start_read),
        .start_addr(start_addr),
        .start_data(start_data),
        .ad_in     (ad_in),
        .busy      (busy),
        .capture   (capture),
        .done      (done),
        .txn_addr  (txn_addr),
        .cs_n      (cs_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .ad        (ad),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe)
    );

endmodule

// File: tb/tb_rtc_bus_seq.sv
// tb_rtc_bus_seq: directed tests for rtc_bus_seq with PHASE_CYC=4 and a simple
// RTC model that answers every read with (address + 0x30).
module tb_rtc_bus_seq;

    localparam int P = 4;
`ifdef RTC_BUS_TIMER_EN
    localparam int NP = 9;
`else
    localparam int NP = 6;
`endif

    logic       clk;
    logic       reset;
    logic [1:0] mode;
    logic       edit_valid;
    logic [7:0] edit_addr;
    logic [7:0] edit_data;
    logic       edit_ready;
    logic       rd_valid;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       init_done;
    logic       busy;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;

    int checks;
    int failures;
    int unsigned cyc;

    logic [7:0]  poll_exp [0:8] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    logic [15:0] init_exp [0:2] = '{16'h0210, 16'h0200, 16'h10D2};
    logic [42:0] reset_exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};

    logic [7:0]  rtc_addr;
    logic        prev_addr;
    logic        prev_wdata;
    logic [15:0] wq[$];
    logic [15:0] rq[$];
    int unsigned acyc[$];

    rtc_bus_seq #(
        .PHASE_CYC(P)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .edit_valid(edit_valid),
        .edit_addr (edit_addr),
        .edit_data (edit_data),
        .edit_ready(edit_ready),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .init_done (init_done),
        .busy      (busy),
        .cs_n      (cs_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .ad        (ad),
        .ad_out    (ad_out),
        .ad_oe     (ad_oe),
        .ad_in     (ad_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RTC model: latch the address phase, answer reads with address + 0x30
    always @(posedge clk or posedge reset) begin
        if (reset) rtc_addr <= 8'h00;
        else if (!cs_n && !ad) rtc_addr <= ad_out;
    end
    assign ad_in = rtc_addr + 8'h30;

    // Bus monitor: address-phase starts, data-phase writes, read returns
    always @(negedge clk) begin
        if (!cs_n && !ad && !prev_addr) acyc.push_back(cyc);
        if (!cs_n && ad && !wr_n && !prev_wdata) wq.push_back({rtc_addr, ad_out});
        if (rd_valid) rq.push_back({rd_addr, rd_data});
        prev_addr  = !cs_n && !ad;
        prev_wdata = !cs_n && ad && !wr_n;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [42:0] outs();
        return {cs_n, rd_n, wr_n, ad, ad_oe, busy, init_done, rd_valid, ad_out, rd_addr, rd_data, 8'h00};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (outs() !== reset_exp) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h", outs(), reset_exp);
        end
        checks++;
        if (edit_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_edit_ready got=%b exp=0", edit_ready);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_init();
        int unsigned n;
        wq.delete();
        acyc.delete();
        mode = 2'b01;
        n = 0;
        while (init_done !== 1'b1 && n < 80) begin
            step();
            n++;
        end
        checks++;
        if (init_done !== 1'b1) begin
            failures++;
            $display("FAIL init_done_timeout got=%b exp=1", init_done);
        end
        checks++;
        if (wq.size() != 3) begin
            failures++;
            $display("FAIL init_write_count got=%0d exp=3", wq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wq[i] !== init_exp[i]) begin
                    failures++;
                    $display("FAIL init_write%0d got=%h exp=%h", i, wq[i], init_exp[i]);
                end
            end
        end
        checks++;
        if (acyc.size() != 3) begin
            failures++;
            $display("FAIL init_addr_count got=%0d exp=3", acyc.size());
        end else begin
            checks++;
            if (acyc[1] - acyc[0] != 11 || acyc[2] - acyc[1] != 11) begin
                failures++;
                $display("FAIL init_spacing got=%0d,%0d exp=11,11", acyc[1] - acyc[0], acyc[2] - acyc[1]);
            end
            checks++;
            if (cyc - acyc[2] != 10) begin
                failures++;
                $display("FAIL init_done_timing got=%0d exp=10", cyc - acyc[2]);
            end
        end
        repeat (15) step();
        checks++;
        if (wq.size() != 3 || busy !== 1'b0) begin
            failures++;
            $display("FAIL init_no_extra got=%0d/%b exp=3/0", wq.size(), busy);
        end
    endtask

    task automatic test_poll();
        int unsigned n;
        logic [15:0] e;
        rq.delete();
        mode = 2'b10;
        n = 0;
        while (rq.size() < NP + 1 && n < (NP + 2) * 11 + 10) begin
            step();
            n++;
        end
        checks++;
        if (rq.size() < NP + 1) begin
            failures++;
            $display("FAIL poll_timeout got=%0d exp=%0d", rq.size(), NP + 1);
        end else begin
            for (int i = 0; i <= NP; i++) begin
                e = {poll_exp[i % NP], poll_exp[i % NP] + 8'h30};
                checks++;
                if (rq[i] !== e) begin
                    failures++;
                    $display("FAIL poll_read%0d got=%h exp=%h", i, rq[i], e);
                end
            end
        end
        mode = 2'b00;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        step();
    endtask

    task automatic test_edit();
        mode = 2'b11;
        edit_valid = 1'b1;
        edit_addr = 8'h22;
        edit_data = 8'h59;
        wq.delete();
        #1;
        checks++;
        if (edit_ready !== 1'b1) begin
            failures++;
            $display("FAIL edit_ready_idle got=%b exp=1", edit_ready);
        end
        step();
        edit_valid = 1'b0;
        checks++;
        if ({busy, cs_n, ad, wr_n, rd_n, ad_oe, ad_out, edit_ready} !== {6'b100011, 8'h22, 1'b0}) begin
            failures++;
            $display("FAIL edit_addr_phase got=%h exp=%h",
                     {busy, cs_n, ad, wr_n, rd_n, ad_oe, ad_out, edit_ready}, {6'b100011, 8'h22, 1'b0});
        end
        repeat (P) step();
        checks++;
        if ({cs_n, rd_n, wr_n, ad_oe, busy} !== 5'b11101) begin
            failures++;
            $display("FAIL edit_gap1 got=%b exp=11101", {cs_n, rd_n, wr_n, ad_oe, busy});
        end
        step();
        checks++;
        if ({cs_n, ad, wr_n, rd_n, ad_oe, ad_out} !== {5'b01011, 8'h59}) begin
            failures++;
            $display("FAIL edit_data_phase got=%h exp=%h", {cs_n, ad, wr_n, rd_n, ad_oe, ad_out}, {5'b01011, 8'h59});
        end
        repeat (P) step();
        checks++;
        if ({cs_n, wr_n, ad_oe, busy, edit_ready} !== 5'b11010) begin
            failures++;
            $display("FAIL edit_gap2 got=%b exp=11010", {cs_n, wr_n, ad_oe, busy, edit_ready});
        end
        step();
        checks++;
        if ({busy, edit_ready} !== 2'b01) begin
            failures++;
            $display("FAIL edit_back_idle got=%b exp=01", {busy, edit_ready});
        end
        checks++;
        if (wq.size() != 1 || wq[0] !== 16'h2259) begin
            failures++;
            $display("FAIL edit_write got=%0d/%h exp=1/2259", wq.size(), (wq.size() > 0) ? wq[0] : 16'h0);
        end
    endtask

    task automatic test_mode_switch();
        int unsigned n;
        rq.delete();
        wq.delete();
        mode = 2'b10;
        n = 0;
        while (busy !== 1'b1 && n < 5) begin
            step();
            n++;
        end
        checks++;
        if ({busy, cs_n, ad} !== 3'b100) begin
            failures++;
            $display("FAIL switch_read_addr got=%b exp=100", {busy, cs_n, ad});
        end
        mode = 2'b11;
        edit_valid = 1'b1;
        edit_addr = 8'h05;
        edit_data = 8'h77;
        #1;
        checks++;
        if (edit_ready !== 1'b0) begin
            failures++;
            $display("FAIL switch_ready_busy got=%b exp=0", edit_ready);
        end
        n = 0;
        while (edit_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (edit_ready !== 1'b1) begin
            failures++;
            $display("FAIL switch_ready_timeout got=%b exp=1", edit_ready);
        end
        checks++;
        if (rq.size() != 1 || rq[0] !== 16'h2151) begin
            failures++;
            $display("FAIL switch_read_done got=%0d/%h exp=1/2151", rq.size(), (rq.size() > 0) ? rq[0] : 16'h0);
        end
        step();
        edit_valid = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 15) begin
            step();
            n++;
        end
        checks++;
        if (wq.size() != 1 || wq[0] !== 16'h0577) begin
            failures++;
            $display("FAIL switch_edit_write got=%0d/%h exp=1/0577", wq.size(), (wq.size() > 0) ? wq[0] : 16'h0);
        end
        mode = 2'b00;
        step();
    endtask

    task automatic test_init_abort();
        int unsigned n;
        step();
        checks++;
        if (init_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_pre_done got=%b exp=0", init_done);
        end
        wq.delete();
        rq.delete();
        mode = 2'b01;
        n = 0;
        while (busy !== 1'b1 && n < 5) begin
            step();
            n++;
        end
        mode = 2'b10;
        n = 0;
        while (rq.size() < 1 && n < 40) begin
            step();
            n++;
        end
        mode = 2'b01;
        checks++;
        if (wq.size() != 1 || wq[0] !== init_exp[0]) begin
            failures++;
            $display("FAIL abort_first_write got=%0d exp=1", wq.size());
        end
        checks++;
        if (rq.size() != 1 || rq[0] !== 16'h2151) begin
            failures++;
            $display("FAIL abort_poll_start got=%0d/%h exp=1/2151", rq.size(), (rq.size() > 0) ? rq[0] : 16'h0);
        end
        checks++;
        if (init_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_done_low got=%b exp=0", init_done);
        end
        n = 0;
        while (init_done !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        checks++;
        if (wq.size() != 4 || init_done !== 1'b1) begin
            failures++;
            $display("FAIL abort_restart got=%0d/%b exp=4/1", wq.size(), init_done);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wq[i + 1] !== init_exp[i]) begin
                    failures++;
                    $display("FAIL abort_rewrite%0d got=%h exp=%h", i, wq[i + 1], init_exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_data();
        mode = 2'b11;
        edit_valid = 1'b1;
        edit_addr = 8'h30;
        edit_data = 8'hAA;
        step();
        edit_valid = 1'b0;
        repeat (P + 1) step();
        checks++;
        if ({cs_n, ad, wr_n, ad_oe} !== 4'b0101) begin
            failures++;
            $display("FAIL midreset_pre got=%b exp=0101", {cs_n, ad, wr_n, ad_oe});
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (outs() !== reset_exp) begin
            failures++;
            $display("FAIL midreset_values got=%h exp=%h", outs(), reset_exp);
        end
        step();
        mode = 2'b00;
        reset = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        prev_addr = 1'b0;
        prev_wdata = 1'b0;
        reset = 1'b1;
        mode = 2'b00;
        edit_valid = 1'b0;
        edit_addr = 8'h00;
        edit_data = 8'h00;
        test_reset();
        test_init();
        test_poll();
        test_edit();
        test_mode_switch();
        test_init_abort();
        test_reset_mid_data();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
